// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: EXE command encodings, multiplier
// iteration count and the EX/MEM payload layout.
package mips_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned CMD_W     = 4;
  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_ITERS);

  typedef enum logic [CMD_W-1:0] {
    EXE_ADD = 4'b0000,
    EXE_SUB = 4'b0010,
    EXE_AND = 4'b0100,
    EXE_OR  = 4'b0101,
    EXE_NOR = 4'b0110,
    EXE_XOR = 4'b0111,
    EXE_SLL = 4'b1000,
    EXE_SRA = 4'b1001,
    EXE_SRL = 4'b1010,
    EXE_MUL = 4'b1100
  } exe_cmd_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Fields carried alongside the result into the MEM stage
  typedef struct packed {
    logic [DATA_W-1:0] st_val;
    logic [REG_W-1:0]  dest;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
  } exe_ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    exe_ctrl_t         ctrl;
  } exe_out_t;

endpackage

// File: rtl/seq_mul32.sv
// Radix-2 shift-add multiplier, one iteration per cycle, low 32 bits.
// Ports: clk, rst (sync, active-high), start (accept operands in IDLE),
//        a/b operands, busy (iterating), done (product valid this cycle),
//        product (accumulator, final value while done).
import mips_pkg::*;

module seq_mul32 (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  mul_state_e             state, state_nxt;
  logic [DATA_W-1:0]      mcand, mcand_nxt;
  logic [DATA_W-1:0]      mplr, mplr_nxt;
  logic [DATA_W-1:0]      acc, acc_nxt;
  logic [MUL_CNT_W-1:0]   cnt, cnt_nxt;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MUL_IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      mplr  <= mplr_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and iteration logic
  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    mplr_nxt  = mplr;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    unique case (state)
      MUL_IDLE: begin
        if (start) begin
          mcand_nxt = a;
          mplr_nxt  = b;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (mplr[0]) acc_nxt = acc + mcand;
        mcand_nxt = mcand << 1;
        mplr_nxt  = mplr >> 1;
        cnt_nxt   = cnt + MUL_CNT_W'(1);
        if (cnt == MUL_CNT_W'(MUL_ITERS - 1)) state_nxt = MUL_DONE;
      end
      MUL_DONE: state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  assign busy    = (state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/exe_stage_mc.sv
// MIPS execute stage: single-cycle ALU plus multi-cycle MUL via seq_mul32,
// with the EX/MEM output register.
// Inputs : clk, rst (sync, active-high), flush, ID/EX fields (Dest_in,
//          Reg2_in, Val1_in, Val2_in, PC_in, Br_taken_in, EXE_CMD_in,
//          MEM_R_EN_in, MEM_W_EN_in, WB_EN_in).
// Outputs: stall, Br_addr, Br_taken (combinational); ALU_result, ST_val,
//          Dest, MEM_R_EN, MEM_W_EN, WB_EN (registered).
import mips_pkg::*;

module exe_stage_mc (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [REG_W-1:0]  Dest_in,
  input  logic [DATA_W-1:0] Reg2_in,
  input  logic [DATA_W-1:0] Val1_in,
  input  logic [DATA_W-1:0] Val2_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              Br_taken_in,
  input  logic [CMD_W-1:0]  EXE_CMD_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              WB_EN_in,
  output logic              stall,
  output logic [DATA_W-1:0] Br_addr,
  output logic              Br_taken,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] ST_val,
  output logic [REG_W-1:0]  Dest,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              WB_EN
);

  logic              mul_start, mul_busy, mul_done, mul_idle;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] alu_c;
  logic [4:0]        shamt;
  exe_ctrl_t         ctrl_in, hold_q;
  exe_out_t          out_d, out_q;

  seq_mul32 u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (Val1_in),
    .b       (Val2_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_idle  = ~mul_busy & ~mul_done;
  assign mul_start = mul_idle & (EXE_CMD_in == EXE_MUL) & ~flush;
  assign stall     = mul_start | mul_busy;

  assign Br_addr  = PC_in + {Val2_in[DATA_W-3:0], 2'b00};
  assign Br_taken = Br_taken_in & ~stall & ~flush;

  // Single-cycle ALU; MUL and unknown codes give 0 here
  always_comb begin
    alu_c = '0;
    shamt = Val2_in[4:0];
    case (EXE_CMD_in)
      EXE_ADD: alu_c = Val1_in + Val2_in;
      EXE_SUB: alu_c = Val1_in - Val2_in;
      EXE_AND: alu_c = Val1_in & Val2_in;
      EXE_OR:  alu_c = Val1_in | Val2_in;
      EXE_NOR: alu_c = ~(Val1_in | Val2_in);
      EXE_XOR: alu_c = Val1_in ^ Val2_in;
      EXE_SLL: alu_c = Val1_in << shamt;
      EXE_SRA: alu_c = $unsigned($signed(Val1_in) >>> shamt);
      EXE_SRL: alu_c = Val1_in >> shamt;
      default: alu_c = '0;
    endcase
  end

  // Output register input: product in DONE, bubble while stalling/flushed
  always_comb begin
    ctrl_in = '{st_val: Reg2_in, dest: Dest_in, mem_r_en: MEM_R_EN_in,
                mem_w_en: MEM_W_EN_in, wb_en: WB_EN_in};
    out_d   = '0;
    if (mul_done) begin
      if (!flush) out_d = '{alu_result: mul_product, ctrl: hold_q};
    end else if (!flush && !stall) begin
      out_d = '{alu_result: alu_c, ctrl: ctrl_in};
    end
  end

  // Passthrough fields of a MUL are latched at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      out_q  <= '0;
    end else begin
      if (mul_start) hold_q <= ctrl_in;
      out_q <= out_d;
    end
  end

  assign ALU_result = out_q.alu_result;
  assign ST_val     = out_q.ctrl.st_val;
  assign Dest       = out_q.ctrl.dest;
  assign MEM_R_EN   = out_q.ctrl.mem_r_en;
  assign MEM_W_EN   = out_q.ctrl.mem_w_en;
  assign WB_EN      = out_q.ctrl.wb_en;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc: directed corner cases plus random
// instructions checked against a transaction-level reference model.
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [4:0]  Dest_in;
  logic [31:0] Reg2_in, Val1_in, Val2_in, PC_in;
  logic        Br_taken_in;
  logic [3:0]  EXE_CMD_in;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic        stall, Br_taken;
  logic [31:0] Br_addr, ALU_result, ST_val;
  logic [4:0]  Dest;
  logic        MEM_R_EN, MEM_W_EN, WB_EN;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mul_vis  = 0;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] a, b, reg2, pc;
    logic [4:0]  dest;
    logic        r, w, wb, br;
  } ins_t;

  exe_stage_mc dut (
    .clk(clk), .rst(rst), .flush(flush), .Dest_in(Dest_in), .Reg2_in(Reg2_in),
    .Val1_in(Val1_in), .Val2_in(Val2_in), .PC_in(PC_in), .Br_taken_in(Br_taken_in),
    .EXE_CMD_in(EXE_CMD_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .WB_EN_in(WB_EN_in), .stall(stall), .Br_addr(Br_addr), .Br_taken(Br_taken),
    .ALU_result(ALU_result), .ST_val(ST_val), .Dest(Dest), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference ALU from the instruction-set definitions
  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[4:0];
    p  = 64'(a) * 64'(b);
    case (cmd)
      4'b0000: return a + b;
      4'b0010: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return ~(a | b);
      4'b0111: return a ^ b;
      4'b1000: return a << sh;
      4'b1001: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'b1010: return a >> sh;
      4'b1100: return p[31:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ctl_of(input ins_t i);
    return 32'({i.dest, i.r, i.w, i.wb});
  endfunction

  task automatic apply(input ins_t i, input logic fl);
    EXE_CMD_in = i.cmd; Val1_in = i.a; Val2_in = i.b; Reg2_in = i.reg2;
    PC_in = i.pc; Dest_in = i.dest; MEM_R_EN_in = i.r; MEM_W_EN_in = i.w;
    WB_EN_in = i.wb; Br_taken_in = i.br; flush = fl;
  endtask

  task automatic check_out(input string tag, input logic [31:0] alu,
                           input logic [31:0] st, input logic [31:0] ctl);
    chk({tag, "_alu"}, ALU_result, alu);
    chk({tag, "_st"}, ST_val, st);
    chk({tag, "_ctl"}, 32'({Dest, MEM_R_EN, MEM_W_EN, WB_EN}), ctl);
  endtask

  // Present one instruction (already past the edge by #1) and follow it to its result
  task automatic run(input ins_t i, input logic fl);
    int  n;
    bit  fin;
    apply(i, fl);
    #3;
    if (i.cmd == 4'b1100 && !fl) begin
      n = 0;
      fin = 0;
      while (!fin) begin
        if (stall) begin
          if (n == 0) chk("mul_br_taken", 32'(Br_taken), 32'h0);
          n++;
          @(posedge clk); #1;
          check_out("mul_bubble", 32'h0, 32'h0, 32'h0);
          if (n > 40) begin
            chk("mul_timeout", 32'(n), 32'd33);
            fin = 1;
          end else if (n <= 20) begin
            // upstream noise and flush during BUSY must not matter
            Val1_in = $urandom; Val2_in = $urandom; Reg2_in = $urandom;
            Dest_in = 5'($urandom); flush = 1'($urandom);
          end else begin
            apply(i, 1'b0);
          end
          #3;
        end else begin
          chk("mul_stall_cycles", 32'(n), 32'd33);
          @(posedge clk); #1;
          check_out("mul_result", ref_alu(i.cmd, i.a, i.b), i.reg2, ctl_of(i));
          mul_vis = cyc;
          fin = 1;
        end
      end
    end else begin
      chk("stall", 32'(stall), 32'h0);
      chk("br_taken", 32'(Br_taken), 32'(i.br & ~fl));
      chk("br_addr", Br_addr, i.pc + (i.b << 2));
      @(posedge clk); #1;
      if (fl) check_out("flush_bubble", 32'h0, 32'h0, 32'h0);
      else    check_out("op", ref_alu(i.cmd, i.a, i.b), i.reg2, ctl_of(i));
    end
  endtask

  function automatic ins_t mk(input logic [3:0] cmd, input logic [31:0] a,
                              input logic [31:0] b);
    ins_t i;
    i = '{cmd: cmd, a: a, b: b, reg2: 32'h1234_5678, pc: 32'h0,
          dest: 5'd9, r: 1'b0, w: 1'b0, wb: 1'b1, br: 1'b0};
    return i;
  endfunction

  initial begin
    ins_t   i;
    int     first_vis;
    logic [3:0] codes [12];
    codes = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'h3, 4'hF};

    rst = 1'b1;
    apply(mk(4'h0, 32'h0, 32'h0), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("reset", 32'h0, 32'h0, 32'h0);
    #3;
    chk("reset_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;

    // Single-cycle corner cases
    run(mk(4'h0, 32'h7FFF_FFFF, 32'h1), 1'b0);
    chk("add_ovf", ALU_result, 32'h8000_0000);
    run(mk(4'h2, 32'd3, 32'd5), 1'b0);
    chk("sub_neg", ALU_result, 32'hFFFF_FFFE);
    run(mk(4'h9, 32'h8000_0000, 32'd4), 1'b0);
    chk("sra", ALU_result, 32'hF800_0000);
    run(mk(4'hA, 32'h8000_0000, 32'd4), 1'b0);
    chk("srl", ALU_result, 32'h0800_0000);
    run(mk(4'h8, 32'h8000_0000, 32'h20), 1'b0);
    chk("sll_wrap", ALU_result, 32'h8000_0000);

    // Multiplies, including back-to-back
    run(mk(4'hC, 32'hFFFF_FFFF, 32'd3), 1'b0);
    chk("mul_neg", ALU_result, 32'hFFFF_FFFD);
    chk("mul_wb", 32'(WB_EN), 32'h1);
    run(mk(4'hC, 32'd6, 32'd7), 1'b0);
    chk("mul_42", ALU_result, 32'd42);
    first_vis = mul_vis;
    run(mk(4'hC, 32'h1_0000, 32'h1_0000), 1'b0);
    chk("mul_2p32", ALU_result, 32'h0);
    chk("mul_b2b_gap", 32'(mul_vis - first_vis), 32'd34);

    // Reset during BUSY iteration 10
    apply(mk(4'hC, 32'd11, 32'd13), 1'b0);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    apply(mk(4'h0, 32'd1, 32'd1), 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_out("mid_mul_reset", 32'h0, 32'h0, 32'h0);
    run(mk(4'h0, 32'd1, 32'd1), 1'b0);
    chk("post_reset_add", ALU_result, 32'd2);

    // Branch with and without flush
    i = mk(4'h3, 32'h0, 32'd4);
    i.br = 1'b1; i.pc = 32'h100;
    run(i, 1'b1);
    run(i, 1'b0);
    chk("br_target_seen", Br_addr, 32'h110);
    // flushed MUL must not start
    run(mk(4'hC, 32'd5, 32'd5), 1'b1);

    // Random instruction stream
    for (int k = 0; k < 60; k++) begin
      i.cmd  = codes[$urandom_range(0, 11)];
      i.a    = $urandom;
      i.b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      i.reg2 = $urandom;
      i.pc   = $urandom;
      i.dest = 5'($urandom);
      i.r    = 1'($urandom);
      i.w    = 1'($urandom);
      i.wb   = 1'($urandom);
      i.br   = 1'($urandom);
      run(i, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_stage_mc.md
EXE_STAGE_MC -- requirements
Module: exe_stage_mc

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 flush  in  1  kill the instruction currently presented; bubble into output register.
REQ-004 Dest_in  in  5  destination register from ID/EX register.
REQ-005 Reg2_in  in  32  rt register value (store data).
REQ-006 Val1_in  in  32  ALU operand A.
REQ-007 Val2_in  in  32  ALU operand B / sign-extended immediate.
REQ-008 PC_in  in  32  PC+4 of the presented instruction.
REQ-009 Br_taken_in  in  1  branch-taken flag from ID.
REQ-010 EXE_CMD_in  in  4  operation code.
REQ-011 MEM_R_EN_in, MEM_W_EN_in, WB_EN_in  in  1 each  control passthrough.
REQ-012 stall  out  1  combinational; 1 = upstream (IF, ID, ID/EX register) SHALL hold all inputs stable.
REQ-013 Br_addr  out  32  combinational PC_in + (Val2_in << 2), modulo 2^32.
REQ-014 Br_taken  out  1  combinational Br_taken_in & ~stall & ~flush.
REQ-015 ALU_result  out  32  registered result to MEM stage.
REQ-016 ST_val  out  32  registered Reg2_in.
REQ-017 Dest, MEM_R_EN, MEM_W_EN, WB_EN  out  5/1/1/1  registered passthrough.

Function
REQ-018 Commands: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLL 1000, SRA 1001, SRL 1010, MUL 1100; any other code yields result 0 with controls passed unchanged.
REQ-019 ADD/SUB wrap modulo 2^32, no overflow flag; shift amount = Val2_in[4:0], shifted operand = Val1_in.
REQ-020 Non-MUL ops: single cycle; output register captures result and passthrough fields at the next edge; stall = 0.
REQ-021 MUL: low 32 bits of Val1_in * Val2_in (signed and unsigned identical), radix-2 shift-add, one iteration per cycle.
REQ-022 FSM states IDLE, BUSY, DONE; IDLE->BUSY when EXE_CMD_in = MUL and flush = 0; BUSY->DONE after 32 iterations (counter 0..31, terminal at 31); DONE->IDLE unconditionally.
REQ-023 stall = 1 in IDLE while MUL is presented (flush = 0) and in every BUSY cycle; stall = 0 in DONE: 33 stall cycles per MUL.
REQ-024 In IDLE-accept and BUSY cycles the output register loads a bubble (all outputs 0).
REQ-025 In DONE the output register captures the product plus held Dest/Reg2/control fields; product visible 34 cycles after MUL is first presented.
REQ-026 flush = 1 in IDLE or DONE: output register loads bubble, no MUL starts; flush during BUSY is ignored (upstream is frozen).
REQ-027 MUL immediately following a MUL (presented in the cycle after DONE) SHALL start normally; no dead cycle beyond DONE.
REQ-028 Operands latched at accept; input changes during BUSY SHALL not affect the product.

Reset
REQ-029 rst = 1 at an edge: FSM -> IDLE, counter/accumulators -> 0, all registered outputs -> 0, including mid-MUL (operation discarded).
REQ-030 rst has priority over flush and FSM transitions; stall = 0 in the cycle following reset.

Structure
REQ-031 EXE_CMD encodings and MUL iteration count (32) SHALL live in shared package mips_pkg, reused by the ID decoder.
REQ-032 Shift-add multiplier SHALL be a sub-module seq_mul32 (start, busy, done, product); ALU and output register stay in exe_stage_mc.

Verification
REQ-033 ADD 0x7FFFFFFF + 0x00000001 -> ALU_result 0x80000000 one edge later; SUB 3-5 -> 0xFFFFFFFE; stall stays 0.
REQ-034 SRA Val1 = 0x80000000, Val2 = 4 -> 0xF8000000; SRL same -> 0x08000000; SLL shamt 32 (Val2 = 0x20) -> shift 0 -> 0x80000000.
REQ-035 MUL 0xFFFFFFFF * 0x00000003 -> stall high 33 cycles, bubbles meanwhile, ALU_result 0xFFFFFFFD with WB_EN = 1 at cycle 34.
REQ-036 Back-to-back MUL 6*7 then MUL 0x10000*0x10000 -> 42, then 0x00000000; second result 34 cycles after the first.
REQ-037 rst asserted at BUSY iteration 10 -> all outputs 0, stall 0 next cycle; a following ADD 1+1 -> 2.
REQ-038 flush with BEQ (Br_taken_in = 1, PC_in = 0x100, Val2 = 4) -> Br_taken 0, output bubble; without flush -> Br_taken 1, Br_addr 0x110.
